// File: rtl/cmp_sort_ctrl.sv
// Block sorter that time-shares one unsigned magnitude comparator to bubble-sort DEPTH samples in place.
// Latency: DEPTH load cycles, DEPTH*(DEPTH-1)/2 sort cycles, then DEPTH drain cycles.
// Backpressure: in_ready only in IDLE/LOAD; output word and last flag hold while out_valid & ~out_ready.
// Optional build macro CMP_SORT_EARLY_EXIT_EN: leaves SORT after the first pass with no swaps.

module cmp_sort_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_last,
    output logic             o_busy
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SORT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_wr_idx;
    logic [IW-1:0]    r_rd_idx;
    logic [IW-1:0]    r_i;
    logic [IW-1:0]    r_lim;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
`ifdef CMP_SORT_EARLY_EXIT_EN
    logic             r_swapped;
`endif

    logic             w_accept;
    logic             w_fire_out;
    logic [IW-1:0]    w_i_nxt;
    logic [IW-1:0]    w_rd_nxt;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_gt;
    logic             w_pass_end;
    logic             w_sort_done;
    logic [WIDTH-1:0] w_head;

    // Handshake and comparator datapath; only gt matters because eq/lt leave the pair in place.
    always_comb begin
        w_accept   = i_in_valid && o_in_ready;
        w_fire_out = r_out_valid && i_out_ready;
        w_i_nxt    = r_i + 1'b1;
        w_rd_nxt   = r_rd_idx + 1'b1;
        w_a        = r_mem[r_i];
        w_b        = r_mem[w_i_nxt];
        w_gt       = (r_state == S_SORT) && (w_a > w_b);
        w_pass_end = (r_i == r_lim - 1'b1);
`ifdef CMP_SORT_EARLY_EXIT_EN
        // A pass with no swap at all means the block is already ordered.
        w_sort_done = w_pass_end && ((r_lim == IW'(1)) || !(r_swapped || w_gt));
`else
        w_sort_done = w_pass_end && (r_lim == IW'(1));
`endif
        // mem[0] as it will look after this cycle's compare, so the first drain word is correct.
        w_head     = ((r_i == '0) && w_gt) ? w_b : r_mem[0];
    end

    // Ready and busy are pure state decodes so in_ready is up right after reset release.
    always_comb begin
        o_in_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
        o_busy     = (r_state == S_SORT) || (r_state == S_DRAIN);
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;

    // Sample storage: written by the input stream while loading, pair-swapped while sorting.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[r_wr_idx] <= i_in_data;
        end else if (w_gt) begin
            r_mem[r_i]     <= w_b;
            r_mem[w_i_nxt] <= w_a;
        end
    end

    // Control FSM with registered stream outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_i         <= '0;
            r_lim       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
`ifdef CMP_SORT_EARLY_EXIT_EN
            r_swapped   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wr_idx <= IW'(1);
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (r_wr_idx == LAST_IDX) begin
                            r_wr_idx  <= '0;
                            r_i       <= '0;
                            r_lim     <= LAST_IDX;
`ifdef CMP_SORT_EARLY_EXIT_EN
                            r_swapped <= 1'b0;
`endif
                            r_state   <= S_SORT;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end
                S_SORT: begin
                    if (w_sort_done) begin
                        r_i         <= '0;
                        r_lim       <= '0;
                        r_rd_idx    <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_head;
                        r_out_last  <= 1'b0;
                        r_state     <= S_DRAIN;
                    end else if (w_pass_end) begin
                        // Largest remaining value has bubbled to lim; shrink the window, no idle cycle.
                        r_i       <= '0;
                        r_lim     <= r_lim - 1'b1;
`ifdef CMP_SORT_EARLY_EXIT_EN
                        r_swapped <= 1'b0;
`endif
                    end else begin
                        r_i       <= w_i_nxt;
`ifdef CMP_SORT_EARLY_EXIT_EN
                        r_swapped <= r_swapped || w_gt;
`endif
                    end
                end
                S_DRAIN: begin
                    if (w_fire_out) begin
                        if (r_rd_idx == LAST_IDX) begin
                            r_rd_idx    <= '0;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_last  <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_rd_idx   <= w_rd_nxt;
                            r_out_data <= r_mem[w_rd_nxt];
                            r_out_last <= (w_rd_nxt == LAST_IDX);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Directed bench for cmp_sort_ctrl (WIDTH=8, DEPTH=8) with hand-computed sorted blocks.
// Checks reset values, sort-cycle counts, drain order, last flag, stall hold and mid-block reset.
// All outputs sampled on the falling edge; inputs driven on the falling edge.

module tb_cmp_sort_ctrl;

    typedef logic [7:0] blk_t [8];

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_in_valid = 1'b0;
    logic       o_in_ready;
    logic [7:0] i_in_data = 8'd0;
    logic       o_out_valid;
    logic       i_out_ready = 1'b0;
    logic [7:0] o_out_data;
    logic       o_out_last;
    logic       o_busy;

    int n_chk  = 0;
    int n_pass = 0;

    cmp_sort_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_last  (o_out_last),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Push eight samples; optional 3-cycle valid gap after the 4th.
    task automatic load8(input blk_t d, input bit gap);
        for (int k = 0; k < 8; k++) begin
            int t = 0;
            while (!o_in_ready && t < 50) begin
                @(negedge i_clk);
                t++;
            end
            if (t >= 50) chk("load_ready_timeout", 0, 1);
            i_in_valid = 1'b1;
            i_in_data  = d[k];
            @(negedge i_clk);
            if (gap && k == 3) begin
                i_in_valid = 1'b0;
                repeat (3) @(negedge i_clk);
            end
        end
        i_in_valid = 1'b0;
    endtask

    // Count SORT cycles (busy without out_valid) and how often in_ready was seen high.
    task automatic sort_phase(output int n, output int rdy_hi);
        n = 0;
        rdy_hi = 0;
        while (o_busy && !o_out_valid && n < 200) begin
            if (o_in_ready) rdy_hi++;
            n++;
            @(negedge i_clk);
        end
    endtask

    // Drain eight words; mode 0 = always ready, mode 1 = ready pattern 1,0,0,1,0,0,...
    task automatic drain8(input blk_t exp, input int mode, output int busy_n);
        int  k = 0;
        int  c = 0;
        bit  hold = 1'b0;
        logic [7:0] hold_d = 8'd0;
        logic       hold_l = 1'b0;
        logic       rdy;
        busy_n = 0;
        chk("drain_first_valid", o_out_valid, 1);
        while (k < 8 && c < 300) begin
            rdy = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            i_out_ready = rdy;
            if (o_busy) busy_n++;
            if (hold) begin
                chk("stall_valid", o_out_valid, 1);
                chk("stall_data", o_out_data, hold_d);
                chk("stall_last", o_out_last, hold_l);
                hold = 1'b0;
            end
            if (o_out_valid) begin
                if (rdy) begin
                    chk($sformatf("out_data[%0d]", k), o_out_data, exp[k]);
                    chk($sformatf("out_last[%0d]", k), o_out_last, (k == 7));
                    k++;
                end else begin
                    hold   = 1'b1;
                    hold_d = o_out_data;
                    hold_l = o_out_last;
                end
            end
            @(negedge i_clk);
            c++;
        end
        i_out_ready = 1'b0;
        chk("drain_count", k, 8);
        chk("post_drain_valid", o_out_valid, 0);
        chk("post_drain_busy", o_busy, 0);
        chk("post_drain_in_ready", o_in_ready, 1);
    endtask

    initial begin
        blk_t din, dexp;
        int   n_sort, rdy_hi, n_busy;

        // Reset state
        #1;
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_out_data", o_out_data, 0);
        chk("rst_out_last", o_out_last, 0);
        chk("rst_busy", o_busy, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("in_ready_after_reset", o_in_ready, 1);

        // 1: reversed block
        din  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        dexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load8(din, 1'b0);
        sort_phase(n_sort, rdy_hi);
        chk("t1_sort_cycles", n_sort, 28);
        drain8(dexp, 0, n_busy);
        chk("t1_busy_cycles", n_sort + n_busy, 36);

        // 2: presorted block
        din = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load8(din, 1'b0);
        sort_phase(n_sort, rdy_hi);
`ifdef CMP_SORT_EARLY_EXIT_EN
        chk("t2_sort_cycles", n_sort, 7);
`else
        chk("t2_sort_cycles", n_sort, 28);
`endif
        drain8(dexp, 0, n_busy);

        // 3: duplicates and unsigned extremes
        din  = '{8'd5, 8'd5, 8'd0, 8'd255, 8'd5, 8'd0, 8'd255, 8'd1};
        dexp = '{8'd0, 8'd0, 8'd1, 8'd5, 8'd5, 8'd5, 8'd255, 8'd255};
        load8(din, 1'b0);
        sort_phase(n_sort, rdy_hi);
        drain8(dexp, 0, n_busy);

        // 4: output stalls with ready pattern 1,0,0,...
        din  = '{8'd40, 8'd10, 8'd70, 8'd20, 8'd80, 8'd30, 8'd60, 8'd50};
        dexp = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        load8(din, 1'b0);
        sort_phase(n_sort, rdy_hi);
        chk("t4_sort_cycles", n_sort, 28);
        drain8(dexp, 1, n_busy);

        // 5: input gap during load, in_valid held high during sort
        din  = '{8'd3, 8'd9, 8'd200, 8'd1, 8'd77, 8'd0, 8'd42, 8'd16};
        dexp = '{8'd0, 8'd1, 8'd3, 8'd9, 8'd16, 8'd42, 8'd77, 8'd200};
        load8(din, 1'b1);
        chk("t5_busy_after_load", o_busy, 1);
        i_in_valid = 1'b1;
        i_in_data  = 8'hFF;
        sort_phase(n_sort, rdy_hi);
        i_in_valid = 1'b0;
        chk("t5_in_ready_in_sort", rdy_hi, 0);
        drain8(dexp, 0, n_busy);

        // 6: reset pulse at SORT cycle 10, then a fresh block
        din = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load8(din, 1'b0);
        repeat (10) @(negedge i_clk);
        chk("t6_busy_before_abort", o_busy, 1);
        i_rst_n = 1'b0;
        #1;
        chk("t6_abort_busy", o_busy, 0);
        chk("t6_abort_out_valid", o_out_valid, 0);
        chk("t6_abort_out_data", o_out_data, 0);
        chk("t6_abort_out_last", o_out_last, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("t6_in_ready_after_abort", o_in_ready, 1);
        din  = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4};
        dexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9};
        load8(din, 1'b0);
        sort_phase(n_sort, rdy_hi);
        drain8(dexp, 0, n_busy);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
